// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver: 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first, sampled in the clk domain.
// frame_valid/frame_err pulse on the 3rd clk edge after the first synchronizer stage captures nCS high.
module spi_frame_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       COPI,
  input  logic       nCS,
  output logic       frame_valid,
  output logic       frame_rw,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic [3:0] err_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    FULL    = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        r_copi_s1, r_copi_s2;
  logic        r_ncs_s1, r_ncs_s2, r_ncs_s3;

  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic        r_pend_ok;
  logic        r_pend_err;
  logic        r_frame_valid;
  logic        r_frame_err;
  logic        r_frame_rw;
  logic [6:0]  r_frame_addr;
  logic [7:0]  r_frame_data;
  logic [3:0]  r_err_cnt;

  logic        w_sclk_rise;
  logic        w_ncs_fall;
  logic        w_ncs_rise;
  logic        w_clr;
  logic        w_shift;
  logic        w_done_ok;
  logic        w_done_err;

  // Synchronizer idle values match an unselected, quiet bus so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_copi_s1 <= 1'b0;
      r_copi_s2 <= 1'b0;
      r_ncs_s1  <= 1'b1;
      r_ncs_s2  <= 1'b1;
      r_ncs_s3  <= 1'b1;
    end else begin
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_copi_s1 <= COPI;
      r_copi_s2 <= r_copi_s1;
      r_ncs_s1  <= nCS;
      r_ncs_s2  <= r_ncs_s1;
      r_ncs_s3  <= r_ncs_s2;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_ncs_fall  = ~r_ncs_s2 & r_ncs_s3;
  assign w_ncs_rise  = r_ncs_s2 & ~r_ncs_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // nCS rise is checked before SCLK rise so a coincident clock edge is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = RECV;
          w_clr       = 1'b1;
        end
      end
      RECV: begin
        if (w_ncs_rise) begin
          w_state_nxt = IDLE;
          w_done_err  = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_cnt == 5'd15) begin
            w_state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (w_ncs_rise) begin
          w_state_nxt = IDLE;
          w_done_ok   = 1'b1;
        end else if (w_sclk_rise) begin
          w_state_nxt = OVERRUN;
        end
      end
      OVERRUN: begin
        if (w_ncs_rise) begin
          w_state_nxt = IDLE;
          w_done_err  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'd0;
    end else if (w_clr) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'd0;
    end else if (w_shift) begin
      r_cnt   <= r_cnt + 5'd1;
      r_shift <= {r_shift[14:0], r_copi_s2};
    end
  end

  // One extra stage between the end-of-frame decision and the output pulse.
  // The shift register is still intact here: a new frame can clear it no earlier than this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ok     <= 1'b0;
      r_pend_err    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_rw    <= 1'b0;
      r_frame_addr  <= 7'd0;
      r_frame_data  <= 8'd0;
      r_err_cnt     <= 4'd0;
    end else begin
      r_pend_ok     <= w_done_ok;
      r_pend_err    <= w_done_err;
      r_frame_valid <= r_pend_ok;
      r_frame_err   <= r_pend_err;
      if (r_pend_ok) begin
        r_frame_rw   <= r_shift[15];
        r_frame_addr <= r_shift[14:8];
        r_frame_data <= r_shift[7:0];
      end
      if (r_pend_err && (r_err_cnt != 4'hF)) begin
        r_err_cnt <= r_err_cnt + 4'd1;
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign frame_rw    = r_frame_rw;
  assign frame_addr  = r_frame_addr;
  assign frame_data  = r_frame_data;
  assign err_cnt     = r_err_cnt;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_spi_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       frame_valid;
  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic [3:0] err_cnt;
  logic       busy;

  spi_frame_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SCLK        (SCLK),
    .COPI        (COPI),
    .nCS         (nCS),
    .frame_valid (frame_valid),
    .frame_rw    (frame_rw),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  // Pulse monitor: counts high cycles of each pulse output, sampled away from the active edge
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
    if (frame_valid === 1'b1 && frame_err === 1'b1) n_both++;
  end

  // Frame-level reference model
  logic       m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  int         m_errs;

  function automatic logic [3:0] m_cnt();
    return (m_errs > 15) ? 4'd15 : 4'(m_errs);
  endfunction

  task automatic model_frame(input logic [31:0] val, input int nbits);
    if (nbits == 16) begin
      m_rw   = val[15];
      m_addr = val[14:8];
      m_data = val[7:0];
    end else begin
      m_errs++;
    end
  endtask

  task automatic model_reset();
    m_rw   = 1'b0;
    m_addr = 7'd0;
    m_data = 8'd0;
    m_errs = 0;
  endtask

  task automatic spi_bits(input logic [31:0] val, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      COPI = val[i];
      repeat (half) @(negedge clk);
      SCLK = 1'b1;
      repeat (half) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] val, input int nbits, input int half);
    @(negedge clk);
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(val, nbits, half);
    repeat (half) @(negedge clk);
    nCS = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SCLK  = 1'b0;
    COPI  = 1'b0;
    nCS   = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({frame_valid, frame_err, frame_rw, frame_addr, frame_data, err_cnt, busy} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {frame_valid, frame_err, frame_rw, frame_addr, frame_data, err_cnt, busy});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_total++;
    if (n_valid + n_err !== 0) begin
      n_bad++;
      $display("FAIL reset_release_pulses got=%0d exp=0", n_valid + n_err);
    end
  endtask

  task automatic test_write();
    int v0 = n_valid;
    int e0 = n_err;
    spi_frame(32'h8155, 16, 4);
    model_frame(32'h8155, 16);
    n_total++;
    if ((n_valid - v0) !== 1 || (n_err - e0) !== 0) begin
      n_bad++;
      $display("FAIL write_pulses got v=%0d e=%0d exp v=1 e=0", n_valid - v0, n_err - e0);
    end
    n_total++;
    if ({frame_rw, frame_addr, frame_data, err_cnt} !== {m_rw, m_addr, m_data, m_cnt()}) begin
      n_bad++;
      $display("FAIL write_fields got=%h/%h/%h cnt=%0d exp=%h/%h/%h cnt=%0d",
               frame_rw, frame_addr, frame_data, err_cnt, m_rw, m_addr, m_data, m_cnt());
    end
  endtask

  task automatic test_latency();
    int lat = 0;
    @(negedge clk);
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(32'hA5C3, 16, 4);
    repeat (4) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_busy got=%b exp=1", busy);
    end
    nCS = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    model_frame(32'hA5C3, 16);
    n_total++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL latency_valid got=%0d exp=4", lat);
    end
    repeat (10) @(negedge clk);
    n_total++;
    if ({frame_rw, frame_addr, frame_data, busy} !== {m_rw, m_addr, m_data, 1'b0}) begin
      n_bad++;
      $display("FAIL latency_fields got=%h/%h/%h busy=%b exp=%h/%h/%h busy=0",
               frame_rw, frame_addr, frame_data, busy, m_rw, m_addr, m_data);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    spi_frame(32'h80FF, 16, 4);
    model_frame(32'h80FF, 16);
    n_total++;
    if ({frame_rw, frame_addr, frame_data} !== {1'b1, 7'h00, 8'hFF}) begin
      n_bad++;
      $display("FAIL b2b_first got=%h/%h/%h exp=1/00/ff", frame_rw, frame_addr, frame_data);
    end
    spi_frame(32'h0400, 16, 4);
    model_frame(32'h0400, 16);
    n_total++;
    if ({frame_rw, frame_addr, frame_data} !== {1'b0, 7'h04, 8'h00}) begin
      n_bad++;
      $display("FAIL b2b_second got=%h/%h/%h exp=0/04/00", frame_rw, frame_addr, frame_data);
    end
    n_total++;
    if ((n_valid - v0) !== 2) begin
      n_bad++;
      $display("FAIL b2b_pulses got=%0d exp=2", n_valid - v0);
    end
  endtask

  task automatic test_short();
    int v0 = n_valid;
    int e0 = n_err;
    spi_frame(32'h1FF, 9, 4);
    model_frame(32'h1FF, 9);
    n_total++;
    if ((n_valid - v0) !== 0 || (n_err - e0) !== 1) begin
      n_bad++;
      $display("FAIL short_pulses got v=%0d e=%0d exp v=0 e=1", n_valid - v0, n_err - e0);
    end
    n_total++;
    if ({frame_rw, frame_addr, frame_data, err_cnt} !== {m_rw, m_addr, m_data, m_cnt()}) begin
      n_bad++;
      $display("FAIL short_fields got=%h/%h/%h cnt=%0d exp=%h/%h/%h cnt=%0d",
               frame_rw, frame_addr, frame_data, err_cnt, m_rw, m_addr, m_data, m_cnt());
    end
  endtask

  task automatic test_zero_bits();
    int e0 = n_err;
    spi_frame(32'h0, 0, 4);
    model_frame(32'h0, 0);
    n_total++;
    if ((n_err - e0) !== 1 || err_cnt !== m_cnt()) begin
      n_bad++;
      $display("FAIL zero_bits got e=%0d cnt=%0d exp e=1 cnt=%0d", n_err - e0, err_cnt, m_cnt());
    end
  endtask

  task automatic test_overrun_saturate();
    int e0 = n_err;
    int v0 = n_valid;
    spi_frame(32'h1_8155, 17, 4);
    model_frame(32'h1_8155, 17);
    n_total++;
    if ((n_err - e0) !== 1 || (n_valid - v0) !== 0 || err_cnt !== m_cnt()) begin
      n_bad++;
      $display("FAIL overrun got e=%0d v=%0d cnt=%0d exp e=1 v=0 cnt=%0d",
               n_err - e0, n_valid - v0, err_cnt, m_cnt());
    end
    for (int i = 0; i < 20; i++) begin
      spi_frame(32'h1_FFFF, 17, 3);
      model_frame(32'h1_FFFF, 17);
    end
    n_total++;
    if (err_cnt !== 4'd15 || m_cnt() !== 4'd15) begin
      n_bad++;
      $display("FAIL saturate got=%0d exp=15", err_cnt);
    end
    n_total++;
    if ({frame_rw, frame_addr, frame_data} !== {m_rw, m_addr, m_data}) begin
      n_bad++;
      $display("FAIL overrun_fields got=%h/%h/%h exp=%h/%h/%h",
               frame_rw, frame_addr, frame_data, m_rw, m_addr, m_data);
    end
  endtask

  task automatic test_idle_sclk();
    int v0 = n_valid;
    int e0 = n_err;
    int busy_hits = 0;
    nCS = 1'b1;
    for (int i = 0; i < 8; i++) begin
      COPI = i[0];
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0) busy_hits++;
      end
      SCLK = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0) busy_hits++;
      end
      SCLK = 1'b0;
    end
    repeat (8) @(negedge clk);
    n_total++;
    if ((n_valid - v0) !== 0 || (n_err - e0) !== 0 || busy_hits !== 0) begin
      n_bad++;
      $display("FAIL idle_sclk got v=%0d e=%0d busy_cycles=%0d exp 0/0/0",
               n_valid - v0, n_err - e0, busy_hits);
    end
  endtask

  task automatic test_mid_reset();
    int v0;
    int e0;
    @(negedge clk);
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(32'h8155 >> 6, 10, 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({frame_valid, frame_err, frame_rw, frame_addr, frame_data, err_cnt, busy} !== 23'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {frame_valid, frame_err, frame_rw, frame_addr, frame_data, err_cnt, busy});
    end
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    nCS  = 1'b1;
    SCLK = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if ((n_valid - v0) !== 0 || (n_err - e0) !== 0) begin
      n_bad++;
      $display("FAIL midreset_pulses got v=%0d e=%0d exp 0/0", n_valid - v0, n_err - e0);
    end
    spi_frame(32'h0233, 16, 4);
    model_frame(32'h0233, 16);
    n_total++;
    if ((n_valid - v0) !== 1 || {frame_rw, frame_addr, frame_data, err_cnt} !== {1'b0, 7'h02, 8'h33, 4'd0}) begin
      n_bad++;
      $display("FAIL midreset_frame got v=%0d %h/%h/%h cnt=%0d exp v=1 0/02/33 cnt=0",
               n_valid - v0, frame_rw, frame_addr, frame_data, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] val;
    int nbits;
    int half;
    int v0;
    int e0;
    int exp_v;
    int exp_e;
    for (int it = 0; it < 24; it++) begin
      nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : 16;
      half  = int'($urandom_range(3, 6));
      val   = $urandom & ((32'd1 << nbits) - 32'd1);
      v0    = n_valid;
      e0    = n_err;
      spi_frame(val, nbits, half);
      model_frame(val, nbits);
      exp_v = (nbits == 16) ? 1 : 0;
      exp_e = 1 - exp_v;
      n_total++;
      if ((n_valid - v0) !== exp_v || (n_err - e0) !== exp_e ||
          {frame_rw, frame_addr, frame_data, err_cnt} !== {m_rw, m_addr, m_data, m_cnt()}) begin
        n_bad++;
        $display("FAIL random[%0d] n=%0d val=%h got v=%0d e=%0d %h/%h/%h cnt=%0d exp v=%0d e=%0d %h/%h/%h cnt=%0d",
                 it, nbits, val, n_valid - v0, n_err - e0, frame_rw, frame_addr, frame_data, err_cnt,
                 exp_v, exp_e, m_rw, m_addr, m_data, m_cnt());
      end
    end
  endtask

  task automatic test_exclusive();
    n_total++;
    if (n_both !== 0) begin
      n_bad++;
      $display("FAIL valid_err_overlap got=%0d exp=0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_latency();
    test_back_to_back();
    test_short();
    test_zero_bits();
    test_overrun_saturate();
    test_idle_sclk();
    test_mid_reset();
    test_random();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
